code_lock_fsm: RTL and testbench

//  Core of the 4-button digital lock. Debounces the four pushbuttons and turns each clean press into a 2-bit digit.

---
 rtl/lock_pkg.sv | 28 ++
 rtl/pb_debounce.sv | 61 ++++++
 rtl/code_lock_fsm.sv | 151 +++++++++++++++
 tb/tb_code_lock_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and helpers for the 4-button code lock.
package lock_pkg;
    localparam int DIGIT_W = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ENTRY   = ST_ENTRY,
        S_CHECK   = ST_CHECK,
        S_OPEN    = ST_OPEN,
        S_FAIL    = ST_FAIL,
        S_LOCKOUT = ST_LOCKOUT
    } state_t;

    // Ceil-log2, floored at 1 so a counter never collapses to zero width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/pb_debounce.sv
// Button synchroniser and shared stability counter; emits one press_evt per clean one-hot press.
module pb_debounce
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         btn,
    output logic               press_evt,
    output logic [DIGIT_W-1:0] digit
);
    localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]         s1, s2, prev;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic               stable_hit, one_hot;
    logic [DIGIT_W-1:0] digit_nx;

    assign stable_hit = (s2 == prev) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign one_hot    = (s2 != 4'd0) && ((s2 & (s2 - 4'd1)) == 4'd0);

    always_comb begin
        digit_nx = '0;
        for (int i = 0; i < 4; i++)
            if (s2[i]) digit_nx = DIGIT_W'(i);
    end

    // armed starts low: a clean release must be seen before the first press counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            prev      <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
            press_evt <= 1'b0;
            digit     <= '0;
        end else begin
            s1        <= btn;
            s2        <= s1;
            prev      <= s2;
            press_evt <= 1'b0;
            if (s2 != prev) begin
                cnt <= '0;
            end else if (stable_hit) begin
                cnt <= '0;
                if (s2 == 4'd0) begin
                    armed <= 1'b1;
                end else if (one_hot && armed) begin
                    press_evt <= 1'b1;
                    digit     <= digit_nx;
                    armed     <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/code_lock_fsm.sv
// Code lock core: slow_clk tick recovery, entry register, tick timer and lock FSM.
module code_lock_fsm
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CODE_LEN        = 4,
    parameter int MAX_FAILS       = 3,
    parameter int UNLOCK_TICKS    = 5,
    parameter int LOCKOUT_TICKS   = 30,
    parameter int ENTRY_TIMEOUT   = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            slow_clk,
    input  logic [3:0]                      btn,
    input  logic [DIGIT_W*CODE_LEN-1:0]     code,
    output logic                            unlocked,
    output logic                            lockout,
    output logic                            err_pulse,
    output logic [clog2(CODE_LEN+1)-1:0]    digit_count
);
    localparam int DC_W    = clog2(CODE_LEN + 1);
    localparam int FC_W    = clog2(MAX_FAILS + 1);
    localparam int T_MAX0  = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS : LOCKOUT_TICKS;
    localparam int TMR_MAX = (T_MAX0 > ENTRY_TIMEOUT) ? T_MAX0 : ENTRY_TIMEOUT;
    localparam int TMR_W   = clog2(TMR_MAX + 1);

    logic               press_evt;
    logic [DIGIT_W-1:0] press_digit;

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .press_evt (press_evt),
        .digit     (press_digit)
    );

    // vld_pipe marks which sync stages hold real samples, so reset zeros never fake an edge.
    logic [2:0] ssync;
    logic [2:0] vld_pipe;
    logic       tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssync    <= '0;
            vld_pipe <= '0;
        end else begin
            ssync    <= {ssync[1:0], slow_clk};
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign tick = ssync[1] & ~ssync[2] & vld_pipe[2];

    state_t                      state_q, state_d;
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic [FC_W-1:0]             fail_cnt_q, fail_cnt_d;
    logic [DC_W-1:0]             digit_count_q, digit_count_d;
    logic [DIGIT_W*CODE_LEN-1:0] entry_q, entry_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            fail_cnt_q    <= '0;
            digit_count_q <= '0;
            entry_q       <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            fail_cnt_q    <= fail_cnt_d;
            digit_count_q <= digit_count_d;
            entry_q       <= entry_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        fail_cnt_d    = fail_cnt_q;
        digit_count_d = digit_count_q;
        entry_d       = entry_q;
        case (state_q)
            S_IDLE: if (press_evt) begin
                entry_d[DIGIT_W-1:0] = press_digit;
                digit_count_d        = DC_W'(1);
                tmr_d                = '0;
                state_d              = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
            end
            S_ENTRY: begin
                if (press_evt) begin
                    for (int k = 0; k < CODE_LEN; k++)
                        if (DC_W'(k) == digit_count_q) entry_d[k*DIGIT_W +: DIGIT_W] = press_digit;
                    digit_count_d = digit_count_q + 1'b1;
                    tmr_d         = '0;
                    if (digit_count_q == DC_W'(CODE_LEN - 1)) state_d = S_CHECK;
                end else if (tick) begin
                    if (tmr_q == TMR_W'(ENTRY_TIMEOUT - 1)) begin
                        state_d       = S_IDLE;
                        digit_count_d = '0;
                        tmr_d         = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                digit_count_d = '0;
                tmr_d         = '0;
                if (entry_q == code) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (fail_cnt_q == FC_W'(MAX_FAILS - 1)) begin
                    state_d    = S_LOCKOUT;
                    fail_cnt_d = '0;
                end else begin
                    state_d    = S_IDLE;
                    fail_cnt_d = fail_cnt_q + 1'b1;
                end
            end
            S_OPEN: if (tick) begin
                if (tmr_q == TMR_W'(UNLOCK_TICKS - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_LOCKOUT: if (tick) begin
                if (tmr_q == TMR_W'(LOCKOUT_TICKS - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign unlocked    = (state_q == S_OPEN);
    assign lockout     = (state_q == S_LOCKOUT);
    assign err_pulse   = (state_q == S_FAIL);
    assign digit_count = digit_count_q;
endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: stimulus pushes expected events, a monitor pops and compares.
module tb_code_lock_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slow_clk = 1'b0;
    logic [3:0] btn = 4'd0;
    logic [7:0] code = 8'b11_10_01_00;
    logic       unlocked, lockout, err_pulse;
    logic [2:0] digit_count;

    always #5 clk = ~clk;

    code_lock_fsm #(
        .DEBOUNCE_CYCLES(4), .CODE_LEN(4), .MAX_FAILS(3),
        .UNLOCK_TICKS(3), .LOCKOUT_TICKS(5), .ENTRY_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .btn(btn), .code(code),
        .unlocked(unlocked), .lockout(lockout), .err_pulse(err_pulse),
        .digit_count(digit_count)
    );

    typedef enum int {EV_PRESS, EV_ERR, EV_OPEN, EV_CLOSE, EV_LOCK, EV_UNLOCK} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_press_cyc = -100;
    int  press_lat = 7;
    int  tick_lat = 2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input ev_kind_t k, input int v);
        exp_q.push_back('{k, v});
    endtask

    task automatic observe(input ev_kind_t k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d expected none (cycle %0d)", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                errors++;
                $display("FAIL event_order: got kind %0d val %0d expected kind %0d val %0d (cycle %0d)",
                         k, v, e.kind, e.val, cyc);
            end
        end
    endtask

    // Monitor: turns output activity into events and checks them against the queue.
    initial begin
        logic p_unl, p_lck;
        p_unl = 1'b0;
        p_lck = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (dut.press_evt) begin
                observe(EV_PRESS, int'(dut.press_digit));
                last_press_cyc = cyc;
            end
            if (err_pulse) observe(EV_ERR, 0);
            if (unlocked && !p_unl) begin
                observe(EV_OPEN, 0);
                chk("open_latency", cyc - last_press_cyc, 2);
            end
            if (!unlocked && p_unl) observe(EV_CLOSE, 0);
            if (lockout && !p_lck) observe(EV_LOCK, 0);
            if (!lockout && p_lck) observe(EV_UNLOCK, 0);
            p_unl = unlocked;
            p_lck = lockout;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int d);
        btn = 4'(1 << d);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (dut.press_evt) press_lat = i;
        end
        btn = 4'd0;
        wait_n(16);
    endtask

    task automatic tick();
        slow_clk = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (dut.tick) tick_lat = i;
        end
        slow_clk = 1'b0;
        wait_n(5);
    endtask

    // res: 0 nothing, 1 opens, 2 wrong code, 3 wrong code into lockout
    task automatic enter(input int a, input int b, input int c, input int e, input int res);
        push(EV_PRESS, a); press(a);
        push(EV_PRESS, b); press(b);
        push(EV_PRESS, c); press(c);
        push(EV_PRESS, e);
        if (res == 1) push(EV_OPEN, 0);
        if (res >= 2) push(EV_ERR, 0);
        if (res == 3) push(EV_LOCK, 0);
        press(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wait_n(3);
        chk("reset_unlocked", unlocked, 0);
        chk("reset_lockout", lockout, 0);
        chk("reset_err_pulse", err_pulse, 0);
        chk("reset_digit_count", digit_count, 0);
        reset = 1'b0;
        wait_n(20);

        // correct code, digit_count progression, open duration
        push(EV_PRESS, 0); press(0); chk("dc_after_1", digit_count, 1);
        push(EV_PRESS, 1); press(1); chk("dc_after_2", digit_count, 2);
        push(EV_PRESS, 2); press(2); chk("dc_after_3", digit_count, 3);
        push(EV_PRESS, 3); push(EV_OPEN, 0); press(3);
        chk("open_unlocked", unlocked, 1);
        chk("open_dc_cleared", digit_count, 0);
        tick(); chk("open_tick1", unlocked, 1);
        tick(); chk("open_tick2", unlocked, 1);
        push(EV_CLOSE, 0);
        tick(); chk("open_tick3_closed", unlocked, 0);

        // wrong code then correct code
        enter(0, 1, 2, 2, 2);
        chk("wrong_unlocked", unlocked, 0);
        chk("wrong_fail_cnt", dut.fail_cnt_q, 1);
        enter(0, 1, 2, 3, 1);
        chk("retry_fail_cnt_cleared", dut.fail_cnt_q, 0);
        repeat (2) tick();
        push(EV_CLOSE, 0);
        tick();

        // three wrong codes -> lockout, correct code ignored
        enter(3, 3, 3, 3, 2);
        enter(1, 1, 1, 1, 2);
        enter(2, 2, 2, 2, 3);
        chk("lockout_set", lockout, 1);
        chk("lockout_fail_cnt", dut.fail_cnt_q, 0);
        enter(0, 1, 2, 3, 0);
        chk("lockout_ignores_code", unlocked, 0);
        repeat (4) tick();
        chk("lockout_tick4", lockout, 1);
        push(EV_UNLOCK, 0);
        tick();
        chk("lockout_released", lockout, 0);
        chk("lockout_idle_dc", digit_count, 0);

        // one wrong code so fail_cnt is nonzero through the timeout test
        enter(3, 2, 1, 0, 2);

        // bounce, multi-bit, long hold
        push(EV_PRESS, 0);
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            wait_n(2);
        end
        btn = 4'b0001; wait_n(16);
        btn = 4'b0000; wait_n(16);
        chk("bounce_one_press", digit_count, 1);
        btn = 4'b0011; wait_n(20);
        btn = 4'b0000; wait_n(16);
        chk("multibit_no_press", digit_count, 1);
        push(EV_PRESS, 2);
        btn = 4'b0100; wait_n(40);
        btn = 4'b0000; wait_n(16);
        chk("long_hold_one_press", digit_count, 2);

        // entry timeout
        repeat (3) tick();
        chk("timeout_tick3_dc", digit_count, 2);
        tick();
        chk("timeout_dc_cleared", digit_count, 0);
        chk("timeout_no_unlock", unlocked, 0);
        chk("timeout_fail_cnt_kept", dut.fail_cnt_q, 1);

        // press and tick in the same cycle
        push(EV_PRESS, 0); press(0);
        tick();
        chk("entry_tmr_one", dut.tmr_q, 1);
        push(EV_PRESS, 1);
        btn = 4'b0010;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == press_lat - tick_lat) slow_clk = 1'b1;
            if (i == press_lat) chk("press_tick_same_cycle", dut.press_evt & dut.tick, 1);
            if (i == press_lat + 1) chk("press_wins_tmr_zero", dut.tmr_q, 0);
            if (i == press_lat + 5) slow_clk = 1'b0;
        end
        btn = 4'b0000;
        wait_n(16);
        chk("collision_dc", digit_count, 2);

        // reset mid-entry
        reset = 1'b1;
        #1;
        chk("reset_mid_entry", {unlocked, lockout, err_pulse, digit_count}, 0);
        wait_n(3);
        reset = 1'b0;
        wait_n(20);
        chk("reset_fail_cnt", dut.fail_cnt_q, 0);

        // reset mid-open
        enter(0, 1, 2, 3, 1);
        tick();
        push(EV_CLOSE, 0);
        reset = 1'b1;
        #1;
        chk("reset_mid_open", {unlocked, lockout, err_pulse, digit_count}, 0);
        wait_n(3);
        reset = 1'b0;
        wait_n(20);

        // fresh entry after reset
        enter(0, 1, 2, 3, 1);
        chk("fresh_open", unlocked, 1);
        repeat (2) tick();
        push(EV_CLOSE, 0);
        tick();
        chk("fresh_closed", unlocked, 0);

        wait_n(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
